// File: rtl/systolic_pe_param_if.sv
// systolic_pe_param_if: signal bundle for one systolic PE.
//   in_word/in_valid/in_ready    : sample stream into the PE (valid/ready)
//   pass_word/pass_valid         : accepted sample forwarded to the next PE
//   out_word/out_valid           : saturated frame sum
//   coef_we/coef_addr/coef_data  : coefficient bank write port
//   tap_idx                      : next tap to be processed (status)
// master = sample source / bank writer, slave = the PE.
interface systolic_pe_param_if #(
    parameter int WORDLENGTH = 16,
    parameter int IDXW = 3
);
    logic [WORDLENGTH-1:0] in_word;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORDLENGTH-1:0] pass_word;
    logic                  pass_valid;
    logic [WORDLENGTH-1:0] out_word;
    logic                  out_valid;
    logic                  coef_we;
    logic [IDXW-1:0]       coef_addr;
    logic [WORDLENGTH-1:0] coef_data;
    logic [IDXW-1:0]       tap_idx;

    modport master (
        output in_word, in_valid, coef_we, coef_addr, coef_data,
        input  in_ready, pass_word, pass_valid, out_word, out_valid, tap_idx
    );
    modport slave (
        input  in_word, in_valid, coef_we, coef_addr, coef_data,
        output in_ready, pass_word, pass_valid, out_word, out_valid, tap_idx
    );
endinterface

// File: rtl/systolic_pe_param.sv
// systolic_pe_param: systolic PE multiplying each sample by a per-tap coefficient,
// accumulating NTAPS saturated products per frame and forwarding samples downstream.
//   clk30x : clock, rising edge
//   reset  : synchronous, active-high; the coefficient bank keeps its contents
//   bus    : systolic_pe_param_if.slave (sample stream, forward, result, bank write, tap_idx)
module systolic_pe_param #(
    parameter int WORDLENGTH = 16,
    parameter int NTAPS = 8,
    parameter int IDXW = 3,
    parameter int FRACBITS = 15
) (
    input logic clk30x,
    input logic reset,
    systolic_pe_param_if.slave bus
);
    localparam int W = WORDLENGTH;
    localparam int AW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int CW = $clog2(W);
    localparam logic signed [2*W:0] SMAX = {{(W + 2){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [2*W:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;
    state_t state, state_next;

    logic [W-1:0] coef [NTAPS];
    logic [W-1:0] c_sel, x_mag, c_mag, mplier;
    logic [2*W-1:0] mcand, prod_mag;
    logic neg, accept, last_bit, last_tap;
    logic [CW-1:0] cnt;
    logic [IDXW-1:0] tap;
    logic signed [W-1:0] acc, acc_next;
    logic signed [2*W-1:0] prod, scaled;
    logic signed [2*W:0] sum;

    assign bus.tap_idx = tap;

    always_ff @(posedge clk30x) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        accept = state == IDLE && bus.in_valid;
        last_bit = cnt == CW'(W - 1);
        last_tap = tap == IDXW'(NTAPS - 1);
        state_next = state == IDLE ? (bus.in_valid ? MULT : IDLE) :
                     state == MULT ? (last_bit ? ACC : MULT) : IDLE;
        bus.in_ready = state == IDLE;
        c_sel = coef[tap[AW-1:0]];
        // Multiply magnitudes; the most negative value maps to its own unsigned magnitude.
        x_mag = bus.in_word[W-1] ? -bus.in_word : bus.in_word;
        c_mag = c_sel[W-1] ? -c_sel : c_sel;
        prod = neg ? -$signed(prod_mag) : $signed(prod_mag);
        scaled = prod >>> FRACBITS;
        // Tap 0 starts a fresh frame, so the previous frame's sum is dropped.
        sum = {scaled[2*W-1], scaled} + (tap == '0 ? '0 : {{(W + 1){acc[W-1]}}, acc});
        acc_next = sum > SMAX ? SMAX[W-1:0] : sum < SMIN ? SMIN[W-1:0] : sum[W-1:0];
    end

    // Bank is deliberately outside reset; a same-edge write is seen by the next capture only.
    always_ff @(posedge clk30x) begin
        if (bus.coef_we && {1'b0, bus.coef_addr} < (IDXW + 1)'(NTAPS))
            coef[bus.coef_addr[AW-1:0]] <= bus.coef_data;
    end

    // Shift-add multiplier works on captured copies, so bank writes cannot disturb it.
    always_ff @(posedge clk30x) begin
        if (accept) begin
            mcand <= {{W{1'b0}}, x_mag};
            mplier <= c_mag;
            neg <= bus.in_word[W-1] ^ c_sel[W-1];
            prod_mag <= '0;
            cnt <= '0;
        end else if (state == MULT) begin
            prod_mag <= mplier[0] ? prod_mag + mcand : prod_mag;
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk30x) begin
        if (reset) begin
            tap <= '0;
            acc <= '0;
            bus.pass_word <= '0;
            bus.pass_valid <= 1'b0;
            bus.out_word <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.pass_valid <= accept;
            bus.out_valid <= state == ACC && last_tap;
            if (accept) bus.pass_word <= bus.in_word;
            if (state == ACC) begin
                acc <= acc_next;
                tap <= last_tap ? '0 : tap + 1'b1;
                if (last_tap) bus.out_word <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_systolic_pe_param.sv
// tb_systolic_pe_param: randomized self-checking bench with a plain-arithmetic frame model.
module tb_systolic_pe_param;
    localparam int W = 16, NT = 8, IW = 4, FB = 15;

    logic clk30x = 1'b0;
    logic reset = 1'b1;
    always #5 clk30x = ~clk30x;

    systolic_pe_param_if #(.WORDLENGTH(W), .IDXW(IW)) bus ();
    systolic_pe_param #(.WORDLENGTH(W), .NTAPS(NT), .IDXW(IW), .FRACBITS(FB)) dut (
        .clk30x(clk30x),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0, errors = 0, cyc = 0, last_xfer = 0;
    bit prev_hold = 0;
    logic [W-1:0] m_coef [NT];
    int m_acc = 0, m_tap = 0;
    logic [W-1:0] pass_q[$], out_q[$];
    int pass_t[$], out_t[$];
    logic [W-1:0] last_out = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clamp(input longint v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : int'(v);
    endfunction

    // Frame model: product, floor-scaled, saturating running sum, emit on last tap.
    task automatic model_xfer(input logic [W-1:0] s);
        longint p;
        p = longint'($signed(s)) * longint'($signed(m_coef[m_tap]));
        m_acc = clamp(longint'(m_tap == 0 ? 0 : m_acc) + (p >>> FB));
        pass_q.push_back(s);
        pass_t.push_back(cyc);
        if (m_tap == NT - 1) begin
            out_q.push_back(W'(m_acc));
            out_t.push_back(cyc + W + 1);
        end
        m_tap = (m_tap + 1) % NT;
    endtask

    always @(posedge clk30x) cyc <= cyc + 1;

    always @(negedge clk30x) begin
        if (bus.pass_valid) begin
            if (pass_q.size() == 0) check("pass_spurious", 32'(bus.pass_valid), 0);
            else begin
                check("pass_word", bus.pass_word, pass_q.pop_front());
                check("pass_latency", cyc, pass_t.pop_front());
            end
        end
        if (bus.out_valid) begin
            last_out = bus.out_word;
            if (out_q.size() == 0) check("out_spurious", 32'(bus.out_valid), 0);
            else begin
                check("out_word", bus.out_word, out_q.pop_front());
                check("out_latency", cyc, out_t.pop_front());
            end
        end
    end

    task automatic wr(input logic [IW-1:0] a, input logic [W-1:0] d);
        bus.coef_we = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        @(posedge clk30x); #1;
        bus.coef_we = 1'b0;
        if (a < NT) m_coef[a] = d;
    endtask

    task automatic send(input logic [W-1:0] s, input bit hold, input bit cw = 0,
                        input logic [IW-1:0] ca = '0, input logic [W-1:0] cd = '0);
        int n = 0;
        bus.in_valid = hold;
        while (!bus.in_ready && n < 100) begin
            if (hold) bus.in_word = W'($urandom);
            @(posedge clk30x); #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", 32'(bus.in_ready), 1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_word = s;
        bus.coef_we = cw;
        bus.coef_addr = ca;
        bus.coef_data = cd;
        @(posedge clk30x); #1;
        if (hold && prev_hold) check("throughput", cyc - last_xfer, W + 2);
        prev_hold = hold;
        last_xfer = cyc;
        model_xfer(s);
        if (cw && ca < NT) m_coef[ca] = cd;
        bus.coef_we = 1'b0;
        if (hold) bus.in_word = W'($urandom);
        else bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid = 1'b0;
        prev_hold = 0;
        while ((out_q.size() != 0 || pass_q.size() != 0 || !bus.in_ready) && n < 200) begin
            @(posedge clk30x); #1;
            n++;
        end
        check("drain_pending", out_q.size(), 0);
    endtask

    task automatic check_rst(input string p);
        check({p, "_in_ready"}, 32'(bus.in_ready), 1);
        check({p, "_pass_word"}, bus.pass_word, 0);
        check({p, "_pass_valid"}, 32'(bus.pass_valid), 0);
        check({p, "_out_word"}, bus.out_word, 0);
        check({p, "_out_valid"}, 32'(bus.out_valid), 0);
        check({p, "_tap_idx"}, bus.tap_idx, 0);
    endtask

    task automatic frame(input logic [W-1:0] s, input bit hold);
        last_out = '0;
        for (int i = 0; i < NT; i++) send(s, hold);
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.coef_we = 1'b0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        repeat (3) @(posedge clk30x);
        #1;
        reset = 1'b0;
        check_rst("reset");

        for (int i = 0; i < NT; i++) wr(IW'(i), 16'h7FFF);
        frame(16'h0100, 0);
        check("f_pos_out", last_out, 16'h07F8);
        check("f_pos_tap", bus.tap_idx, 0);

        for (int i = 0; i < 4; i++) send(16'h0100, 0);
        repeat (5) @(posedge clk30x);
        #1;
        check("mid_tap", bus.tap_idx, 3);
        reset = 1'b1;
        @(posedge clk30x); #1;
        reset = 1'b0;
        m_acc = 0;
        m_tap = 0;
        check_rst("mid_reset");
        drain();
        frame(16'h0100, 0);
        check("f_after_rst_out", last_out, 16'h07F8);

        bus.in_valid = 1'b1;
        bus.in_word = 16'h1234;
        reset = 1'b1;
        @(posedge clk30x); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_win_pass_valid", 32'(bus.pass_valid), 0);
        check("rst_win_pass_word", bus.pass_word, 0);
        check("rst_win_tap", bus.tap_idx, 0);
        repeat (3) @(posedge clk30x);
        #1;

        frame(16'hFF00, 0);
        check("f_neg_out", last_out, 16'hF800);

        for (int i = 0; i < NT; i++) wr(IW'(i), 16'h4000);
        frame(16'h2000, 1);
        check("f_sat_hi", last_out, 16'h7FFF);
        frame(16'hE000, 1);
        check("f_sat_lo", last_out, 16'h8000);

        for (int i = 0; i < NT; i++) wr(IW'(i), 16'h7FFF);
        last_out = '0;
        send(16'h0100, 0, 1, '0, 16'h0000);
        send(16'h0100, 0);
        wr(IW'(1), 16'h0000);
        for (int i = 2; i < NT; i++) send(16'h0100, 0);
        drain();
        check("f_collide_out", last_out, 16'h07F8);
        wr(IW'(8), 16'h1111);
        wr(IW'(15), 16'h2222);
        frame(16'h0100, 0);
        check("f_addr_oob_out", last_out, 16'h05FA);

        for (int f = 0; f < 6; f++) begin
            for (int t = 0; t < NT; t++) wr(IW'(t), f == 4 ? 16'h8000 : W'($urandom));
            for (int i = 0; i < NT; i++) send(f == 4 ? 16'h8000 : W'($urandom), f[0]);
            drain();
        end
        check("final_tap", bus.tap_idx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
